// File: rtl/rf_dump_reader_pkg.sv
// Shared register-file debug definitions: dump FSM encodings and RF geometry.
// The protocol bench and the UART framer import these as well.
package rf_dump_reader_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEL  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks register-file debug indices FIRST_REG..LAST_REG and streams {index, value}
// words over valid/ready, with a running wrapping checksum and a done pulse.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int AW        = RF_AW,
  parameter int DW        = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] reg_sel,
  input  logic [DW-1:0] reg_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= RF_NREGS) begin : g_bad_range
    $error("rf_dump_reader: need 0 <= FIRST_REG <= LAST_REG < %0d", RF_NREGS);
  end

  localparam logic [AW-1:0] L_FIRST = AW'(FIRST_REG);
  localparam logic [AW-1:0] L_LAST  = AW'(LAST_REG);

  logic [1:0]    r_state;
  // The walk index is the registered reg_sel itself; it holds its value on abort.
  logic [AW-1:0] r_idx;
  logic          r_out_valid;
  logic [AW-1:0] r_out_idx;
  logic [DW-1:0] r_out_data;
  logic [DW-1:0] r_checksum;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_checksum  <= '0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_SEL;
            r_idx      <= L_FIRST;
            r_checksum <= '0;
          end
        end
        S_SEL: begin
          r_state     <= S_SEND;
          r_out_data  <= reg_data;
          r_out_idx   <= r_idx;
          r_out_valid <= 1'b1;
          r_checksum  <= r_checksum + reg_data;
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == L_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_SEL;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reg_sel   = r_idx;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign checksum  = r_checksum;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: full dump, backpressure, abort, ignored starts,
// single-register instance, start+abort in IDLE and reset mid-dump.
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main instance: full 0..31 dump
  logic        start, abort, out_ready;
  logic [4:0]  reg_sel, out_idx;
  logic [31:0] reg_data, out_data, checksum;
  logic        out_valid, busy, done;

  // Single-register instance: 7..7
  logic        start1, abort1, out_ready1;
  logic [4:0]  reg_sel1, out_idx1;
  logic [31:0] reg_data1, out_data1, checksum1;
  logic        out_valid1, busy1, done1;

  logic [31:0] rf [32];
  assign reg_data  = rf[reg_sel];
  assign reg_data1 = (reg_sel1 == 5'd7) ? 32'hDEADBEEF : 32'h0BAD0BAD;

  rf_dump_reader u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .reg_sel(reg_sel), .reg_data(reg_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  rf_dump_reader #(.FIRST_REG(7), .LAST_REG(7)) u_one (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .reg_sel(reg_sel1), .reg_data(reg_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_idx(out_idx1), .out_data(out_data1),
    .busy(busy1), .done(done1), .checksum(checksum1)
  );

  int errors = 0;
  int checks = 0;

  int          got_idx[$];
  logic [31:0] got_data[$];
  int          n_done, done_edge, last_hs_edge;

  // Starts a dump on the main instance and records every accepted word.
  // bp: ready only 1 of 3 cycles. poke: extra start pulses while busy and in DONE.
  task automatic collect(input bit bp, input bit poke, input int budget);
    bit          seen_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [4:0]  prev_idx = '0;
    logic [31:0] prev_data = '0;
    int          e = 0;
    got_idx.delete();
    got_data.delete();
    n_done = 0; done_edge = -1; last_hs_edge = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    while (e < budget) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = bp ? ((e % 3) == 2) : 1'b1;
      if (poke && e == 7) start = 1'b1;
      if (done) begin
        n_done++;
        if (!seen_done) done_edge = e;
        seen_done = 1'b1;
        if (poke) start = 1'b1;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== prev_idx || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_stable e=%0d got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                   e, out_valid, out_idx, out_data, prev_idx, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        got_idx.push_back(int'(out_idx));
        got_data.push_back(out_data);
        last_hs_edge = e + 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_idx;
      prev_data  = out_data;
      if (seen_done && e >= done_edge + 4) break;
      @(posedge clk);
      e++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL dump_timeout got no done within %0d cycles, want done", budget);
    end
  endtask

  task automatic check_words();
    checks++;
    if (got_idx.size() != 32) begin
      errors++;
      $display("FAIL word_count got %0d want 32", got_idx.size());
    end
    for (int i = 0; i < 32 && i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] != i || got_data[i] !== 32'(i) * 32'h11111111) begin
        errors++;
        $display("FAIL word[%0d] got idx=%0d data=%h want idx=%0d data=%h",
                 i, got_idx[i], got_data[i], i, 32'(i) * 32'h11111111);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; out_ready = 0;
    start1 = 0; abort1 = 0; out_ready1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_sel, out_valid, out_idx, out_data, busy, done, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_state got sel=%0d v=%b idx=%0d data=%h busy=%b done=%b cs=%h want all 0",
               reg_sel, out_valid, out_idx, out_data, busy, done, checksum);
    end
    checks++;
    if ({out_valid1, busy1, done1, checksum1} !== '0) begin
      errors++;
      $display("FAIL reset_state_one got v=%b busy=%b done=%b cs=%h want all 0",
               out_valid1, busy1, done1, checksum1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    collect(1'b0, 1'b0, 200);
    check_words();
    checks++;
    if (last_hs_edge != 64 || done_edge != 64) begin
      errors++;
      $display("FAIL full_timing got last_hs=k+%0d done=k+%0d want k+64 k+64", last_hs_edge, done_edge);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL full_done_pulse got %0d cycles want 1", n_done);
    end
    checks++;
    if (checksum !== 32'h111110F0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_checksum got cs=%h busy=%b want cs=111110f0 busy=0", checksum, busy);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || reg_sel !== 5'd31 || out_valid !== 1'b0 || checksum !== 32'h111110F0) begin
      errors++;
      $display("FAIL start_abort_idle got busy=%b sel=%0d v=%b cs=%h want busy=0 sel=31 v=0 cs=111110f0",
               busy, reg_sel, out_valid, checksum);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle_late got busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    collect(1'b1, 1'b0, 400);
    check_words();
    checks++;
    if (n_done != 1 || checksum !== 32'h111110F0) begin
      errors++;
      $display("FAIL bp_done got pulses=%0d cs=%h want 1 111110f0", n_done, checksum);
    end
  endtask

  task automatic test_start_ignored();
    collect(1'b0, 1'b1, 200);
    check_words();
    checks++;
    if (n_done != 1 || done_edge != 64 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored got pulses=%0d done=k+%0d busy=%b want 1 k+64 0",
               n_done, done_edge, busy);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    while (!(out_valid && out_idx == 5'd10) && n < 60) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd10 || out_data !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL abort_stalled got v=%b idx=%0d data=%h want v=1 idx=10 data=aaaaaaaa",
               out_valid, out_idx, out_data);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk); abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        checksum !== 32'hAAAAAAA7 || reg_sel !== 5'd10) begin
      errors++;
      $display("FAIL abort_effect got v=%b busy=%b done=%b cs=%h sel=%0d want 0 0 0 aaaaaaa7 10",
               out_valid, busy, done, checksum, reg_sel);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got done=%b busy=%b want 0 0", done, busy);
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    checks++;
    if (checksum !== 32'h0 || reg_sel !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart got cs=%h sel=%0d busy=%b want 0 0 1", checksum, reg_sel, busy);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start1 = 1'b0; out_ready1 = 1'b1;
    checks++;
    if (busy1 !== 1'b1 || reg_sel1 !== 5'd7 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_sel got busy=%b sel=%0d v=%b want 1 7 0", busy1, reg_sel1, out_valid1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid1 !== 1'b1 || out_idx1 !== 5'd7 || out_data1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_word got v=%b idx=%0d data=%h want 1 7 deadbeef", out_valid1, out_idx1, out_data1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || out_valid1 !== 1'b0 || checksum1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_done got done=%b v=%b cs=%h want 1 0 deadbeef", done1, out_valid1, checksum1);
    end
    @(posedge clk);
    @(negedge clk); out_ready1 = 1'b0;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || checksum1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_idle got done=%b busy=%b cs=%h want 0 0 deadbeef", done1, busy1, checksum1);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (19) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({reg_sel, out_valid, out_idx, out_data, busy, done, checksum} !== '0) begin
      errors++;
      $display("FAIL rst_mid got sel=%0d v=%b idx=%0d data=%h busy=%b done=%b cs=%h want all 0",
               reg_sel, out_valid, out_idx, out_data, busy, done, checksum);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after[%0d] got done=%b busy=%b v=%b want 0 0 0", i, done, busy, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11111111;
    test_reset();
    test_full_dump();
    test_start_abort_idle();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_single();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
